// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI peripheral endpoint.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SPI_DW    = 32;
    localparam int SPI_CNT_W = $clog2(SPI_DW) + 1;

    function automatic int cnt_width(input int dw);
        return $clog2(dw) + 1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// One-input synchroniser with history flop and rise/fall detection.
// Edges are suppressed until the chain holds only post-reset samples.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES:0]   r_vld;
    logic                   r_hist;
    logic                   w_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_hist <= RST_VAL;
            r_vld  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_hist <= w_sync;
            r_vld  <= {r_vld[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign o_sync = w_sync;
    assign o_rise = r_vld[SYNC_STAGES] & ~r_hist &  w_sync;
    assign o_fall = r_vld[SYNC_STAGES] &  r_hist & ~w_sync;

endmodule

// File: rtl/spi_slave_if.sv
// SPI peripheral endpoint: 32-bit MSB-first frames, mosi/miso moved on sck fall.
// Define SPI_SLAVE_FRAME_CNT_EN to build the good-frame counter.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int DW          = SPI_DW,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs_n,
    input  logic          sck,
    input  logic          mosi,
    output logic          miso,
    output logic          miso_oe,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_load,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          frame_err,
    output logic          tx_underrun,
    output logic          busy,
    output logic [15:0]   frame_cnt
);

    localparam int            CW       = cnt_width(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DW);

    logic w_cs_s, w_cs_rise, w_cs_fall;
    logic w_sck_s, w_sck_rise, w_sck_fall;
    logic w_mosi_s, w_mosi_rise, w_mosi_fall;
    logic w_unused_sync;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst(rst), .i_d(cs_n),
        .o_sync(w_cs_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst(rst), .i_d(sck),
        .o_sync(w_sck_s), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .i_d(mosi),
        .o_sync(w_mosi_s), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused_sync = ^{w_sck_s, w_sck_rise, w_mosi_rise, w_mosi_fall};

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_rx_sh, r_rx_data, r_tx_sh, r_tx_buf;
    logic          r_tx_full, r_rx_valid, r_frame_err, r_tx_underrun;
    logic          w_start, w_shift, w_commit, w_abort, w_busy;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_next = SHIFT;
            SHIFT: begin
                if (w_commit)     w_next = DONE;
                else if (w_abort) w_next = IDLE;
            end
            DONE:    if (w_cs_s) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A final sck fall coinciding with cs_n rise still completes the frame.
    always_comb begin
        w_start  = 1'b0;
        w_shift  = 1'b0;
        w_commit = 1'b0;
        w_abort  = 1'b0;
        w_busy   = 1'b0;
        unique case (r_state)
            IDLE:  w_start = w_cs_fall;
            SHIFT: begin
                w_busy   = 1'b1;
                w_commit = (r_cnt == CNT_FULL);
                w_shift  = w_sck_fall && !w_commit;
                w_abort  = w_cs_rise && !w_commit
                        && !(w_shift && r_cnt == CNT_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_rx_sh       <= '0;
            r_rx_data     <= '0;
            r_tx_sh       <= '0;
            r_tx_buf      <= '0;
            r_tx_full     <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_rx_valid    <= w_commit;
            r_frame_err   <= w_abort;
            r_tx_underrun <= w_start && !r_tx_full;
            if (w_start) begin
                r_cnt     <= '0;
                r_tx_sh   <= r_tx_full ? r_tx_buf : '0;
                r_tx_full <= 1'b0;
            end
            if (w_shift) begin
                r_rx_sh <= {r_rx_sh[DW-2:0], w_mosi_s};
                r_tx_sh <= {r_tx_sh[DW-2:0], 1'b0};
                r_cnt   <= r_cnt + CW'(1);
            end
            if (w_commit) r_rx_data <= r_rx_sh;
            if (tx_load && !r_tx_full) begin
                r_tx_buf  <= tx_data;
                r_tx_full <= 1'b1;
            end
        end
    end

    assign miso        = r_tx_sh[DW-1];
    assign miso_oe     = ~w_cs_s;
    assign tx_ready    = ~r_tx_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign tx_underrun = r_tx_underrun;
    assign busy        = w_busy;

`ifdef SPI_SLAVE_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst)             r_frame_cnt <= '0;
        else if (r_rx_valid) r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if acting as master at sck = clk/16.
module tb_spi_slave_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        miso, miso_oe;
    logic [31:0] tx_data = '0;
    logic        tx_load = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, frame_err, tx_underrun, busy;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;
    int n_rxv = 0;
    int n_ferr = 0;
    int n_unr = 0;
    logic [31:0] last_rx = '0;

    always #10 clk = ~clk;

    spi_slave_if dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .tx_underrun(tx_underrun), .busy(busy), .frame_cnt(frame_cnt)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            n_rxv++;
            last_rx = rx_data;
        end
        if (frame_err) n_ferr++;
        if (tx_underrun) n_unr++;
    end

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic load(input logic [31:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic spi_bits(input logic [31:0] w, input int n,
                            output logic [31:0] rd);
        rd = '0;
        for (int i = 0; i < n; i++) begin
            repeat (8) @(negedge clk);
            sck = 1'b1;
            rd = {rd[30:0], miso};
            mosi = w[31-i];
            repeat (8) @(negedge clk);
            sck = 1'b0;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [31:0] w, input int gap,
                             output logic [31:0] rd);
        @(negedge clk) cs_n = 1'b0;
        spi_bits(w, 32, rd);
        cs_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rx_data !== 32'h0) begin
            errors++; $display("FAIL reset_rx_data got=%h exp=0", rx_data);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready);
        end
        checks++;
        if ({miso, miso_oe, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_miso_oe_busy got=%b exp=000",
                     {miso, miso_oe, busy});
        end
        checks++;
        if ({rx_valid, frame_err, tx_underrun} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses got=%b exp=000",
                     {rx_valid, frame_err, tx_underrun});
        end
        checks++;
        if (frame_cnt !== 16'h0) begin
            errors++; $display("FAIL reset_frame_cnt got=%h exp=0", frame_cnt);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        int v0, u0;
        load(32'hA5A5_0F0F);
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++; $display("FAIL basic_ready_low got=%b exp=0", tx_ready);
        end
        v0 = n_rxv; u0 = n_unr;
        spi_frame(32'h1234_5678, 16, rd);
        checks++;
        if (n_rxv - v0 !== 1) begin
            errors++; $display("FAIL basic_rx_valid got=%0d exp=1", n_rxv - v0);
        end
        checks++;
        if (last_rx !== 32'h1234_5678) begin
            errors++; $display("FAIL basic_rx_data got=%h exp=12345678", last_rx);
        end
        checks++;
        if (rd !== 32'hA5A5_0F0F) begin
            errors++; $display("FAIL basic_miso got=%h exp=a5a50f0f", rd);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++; $display("FAIL basic_ready_back got=%b exp=1", tx_ready);
        end
        checks++;
        if (n_unr - u0 !== 0) begin
            errors++; $display("FAIL basic_underrun got=%0d exp=0", n_unr - u0);
        end
    endtask

    task automatic test_underrun();
        logic [31:0] rd;
        int v0, u0;
        v0 = n_rxv; u0 = n_unr;
        spi_frame(32'hCAFE_BABE, 16, rd);
        checks++;
        if (n_unr - u0 !== 1) begin
            errors++; $display("FAIL underrun_pulse got=%0d exp=1", n_unr - u0);
        end
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL underrun_miso got=%h exp=0", rd);
        end
        checks++;
        if (n_rxv - v0 !== 1 || rx_data !== 32'hCAFE_BABE) begin
            errors++;
            $display("FAIL underrun_rx got=%0d/%h exp=1/cafebabe",
                     n_rxv - v0, rx_data);
        end
    endtask

    task automatic test_frame_err();
        logic [31:0] rd;
        int v0, f0;
        v0 = n_rxv; f0 = n_ferr;
        @(negedge clk) cs_n = 1'b0;
        checks++;
        repeat (6) @(negedge clk);
        if (busy !== 1'b1 || miso_oe !== 1'b1) begin
            errors++;
            $display("FAIL ferr_busy_oe got=%b%b exp=11", busy, miso_oe);
        end
        spi_bits(32'h0F0F_0F0F, 17, rd);
        cs_n = 1'b1;
        repeat (16) @(negedge clk);
        checks++;
        if (n_ferr - f0 !== 1) begin
            errors++; $display("FAIL ferr_pulse got=%0d exp=1", n_ferr - f0);
        end
        checks++;
        if (n_rxv - v0 !== 0) begin
            errors++; $display("FAIL ferr_no_valid got=%0d exp=0", n_rxv - v0);
        end
        checks++;
        if (rx_data !== 32'hCAFE_BABE) begin
            errors++; $display("FAIL ferr_rx_hold got=%h exp=cafebabe", rx_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int v0, f0, u0;
        @(negedge clk) cs_n = 1'b0;
        spi_bits(32'h5555_AAAA, 10, rd);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rx_data, tx_ready, miso, miso_oe, busy} !== {32'h0, 4'b1000}) begin
            errors++;
            $display("FAIL rstmid_outputs got=%h/%b exp=0/1000", rx_data,
                     {tx_ready, miso, miso_oe, busy});
        end
        rst = 1'b0;
        v0 = n_rxv; f0 = n_ferr; u0 = n_unr;
        spi_bits(32'h5555_AAAA, 22, rd);
        cs_n = 1'b1;
        repeat (16) @(negedge clk);
        checks++;
        if (n_rxv != v0 || n_ferr != f0 || n_unr != u0) begin
            errors++;
            $display("FAIL rstmid_no_pulse got=%0d/%0d/%0d exp=0/0/0",
                     n_rxv - v0, n_ferr - f0, n_unr - u0);
        end
        load(32'h0000_0001);
        spi_frame(32'hFFFF_FFFF, 16, rd);
        checks++;
        if (rx_data !== 32'hFFFF_FFFF || n_rxv - v0 !== 1) begin
            errors++;
            $display("FAIL rstmid_next_rx got=%h/%0d exp=ffffffff/1",
                     rx_data, n_rxv - v0);
        end
        checks++;
        if (rd !== 32'h0000_0001) begin
            errors++; $display("FAIL rstmid_next_miso got=%h exp=00000001", rd);
        end
    endtask

    task automatic test_double_load();
        logic [31:0] rd;
        load(32'hDEAD_BEEF);
        load(32'h0BAD_F00D);
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++; $display("FAIL dload_ready got=%b exp=0", tx_ready);
        end
        spi_frame(32'h0000_0000, 16, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL dload_miso got=%h exp=deadbeef", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [31:0] tx_v [3];
        logic [31:0] rx_v [3];
        int v0;
        logic [15:0] exp_fc;
        tx_v[0] = 32'h1111_1111; rx_v[0] = 32'h8000_0001;
        tx_v[1] = 32'h2222_2222; rx_v[1] = 32'h0123_4567;
        tx_v[2] = 32'h3333_3333; rx_v[2] = 32'hFEDC_BA98;
        do_reset();
        v0 = n_rxv;
        for (int k = 0; k < 3; k++) begin
            load(tx_v[k]);
            spi_frame(rx_v[k], 400, rd);
            checks++;
            if (rd !== tx_v[k] || last_rx !== rx_v[k]) begin
                errors++;
                $display("FAIL b2b_frame%0d got=%h/%h exp=%h/%h", k,
                         rd, last_rx, tx_v[k], rx_v[k]);
            end
        end
        checks++;
        if (n_rxv - v0 !== 3) begin
            errors++; $display("FAIL b2b_valid_count got=%0d exp=3", n_rxv - v0);
        end
`ifdef SPI_SLAVE_FRAME_CNT_EN
        exp_fc = 16'd3;
`else
        exp_fc = 16'd0;
`endif
        checks++;
        if (frame_cnt !== exp_fc) begin
            errors++;
            $display("FAIL b2b_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_frame_err();
        test_reset_mid();
        test_double_load();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI peripheral-side endpoint for the 32-bit, MSB-first, active-low-CS SPI link driven by our SPI master.
- Oversamples cs_n, sck and mosi in the clk domain and deserialises the mosi word.
- Serialises a pre-loaded response word on miso in the same frame.
- Sits behind the pads of an FPGA-side test target, or in the loopback bench opposite the master.

Parameters:
- DW, 32, frame length in bits; also the width of tx_data and rx_data.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers. Minimum 2.

Ports:
- clk  in  1  system clock, 50 MHz nominal
- rst  in  1  synchronous reset, active-high
- cs_n  in  1  SPI chip select from master, active low, asynchronous
- sck  in  1  SPI clock from master, asynchronous
- mosi  in  1  SPI data from master
- miso  out  1  SPI data to master
- miso_oe  out  1  miso output enable; high only while the synced cs_n is low
- tx_data  in  DW  response word for the next frame
- tx_load  in  1  write strobe for tx_data; accepted only when tx_ready=1
- tx_ready  out  1  tx buffer empty
- rx_data  out  DW  last complete received word; holds its value between frames
- rx_valid  out  1  1-cycle pulse when rx_data is updated
- frame_err  out  1  1-cycle pulse when cs_n rises before DW bits are received
- tx_underrun  out  1  1-cycle pulse when a frame starts with the tx buffer empty
- busy  out  1  high while the state machine is in SHIFT
- frame_cnt  out  16  count of good frames (see Optional Feature)

Behaviour:
- Reset, synchronous active-high on clk:
  - State = IDLE. Bit counter = 0. tx buffer empty, so tx_ready=1.
  - rx_data=0, miso=0, miso_oe=0.
  - All pulse outputs 0. frame_cnt=0.
- Synchronisation:
  - cs_n, sck and mosi each pass through SYNC_STAGES flip-flops plus one history flop.
  - Edges are detected as (history, synced) pairs. All three inputs see equal delay, so mosi stays aligned to the sck edges.
- SPI mode, matching the master:
  - Master drives mosi after each sck rise and samples miso on each sck rise.
  - The slave samples mosi on each detected sck fall.
  - The slave advances miso on each detected sck fall.
- Timing limit: sck half-period must be at least SYNC_STAGES+2 clk cycles. At 50 MHz this covers master sck rates up to 6.25 MHz; 12.5 MHz is unsupported.
- State machine IDLE -> SHIFT -> DONE -> IDLE:
  - IDLE, on cs_n fall detected:
    - If the buffer is full: load the tx shift register from the buffer; the buffer becomes empty.
    - If the buffer is empty: load all zeros and pulse tx_underrun.
    - Bit counter = 0. miso = shift[DW-1]. Go to SHIFT.
  - SHIFT, on each sck fall:
    - rx_shift = {rx_shift[DW-2:0], mosi_sync}.
    - Bit counter increments.
    - tx shift moves left by one; miso = new shift[DW-1].
  - SHIFT, when the counter reaches DW:
    - rx_data <= rx_shift. rx_valid pulses on the following cycle.
    - Go to DONE.
  - SHIFT, cs_n rise detected with counter < DW: pulse frame_err, leave rx_data unchanged, go to IDLE.
  - SHIFT, sck fall and cs_n rise in the same cycle: process the sck fall first, then evaluate the counter. If this fall was bit DW, the frame is good.
  - DONE: sck edges are ignored; extra bits are discarded without error. On cs_n rise, go to IDLE.
- miso_oe follows the synced cs_n inverted in every state. miso holds its value while in DONE.
- TX handshake:
  - tx_load && tx_ready writes the buffer; tx_ready drops on the next cycle.
  - tx_load while tx_ready=0 is ignored.
  - A load in the same cycle as a frame start goes into the now-free buffer for the next frame.
- Reset mid-frame aborts the frame silently: no frame_err, no rx_valid.

Optional Feature:
- Macro: SPI_SLAVE_FRAME_CNT_EN.
- Defined: frame_cnt increments by 1 on each rx_valid, wraps from 0xFFFF to 0, and is cleared by rst.
- Undefined: the counter logic is not generated and frame_cnt is tied to 0. The port exists in both builds.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, SHIFT, DONE)
  - the default frame length constant (32)
  - the bit-counter width constant, $clog2(DW)+1.
- Sub-module spi_sync_edge: one input's synchroniser plus rise/fall detection, with a SYNC_STAGES parameter. Instantiated three times.

Test Plan:
- Load tx_data=0xA5A5_0F0F, then have the master send 0x1234_5678 at sck=clk/16. Expect a single rx_valid with rx_data=0x1234_5678, the master reading 0xA5A5_0F0F, and tx_ready back to 1.
- Start a frame with no tx_load. Expect tx_underrun pulsed once, miso=0 for all 32 bits, and rx_data still updated.
- Raise cs_n after 17 bits. Expect frame_err pulsed once, no rx_valid, and rx_data keeping its previous value.
- Assert rst after 10 bits. Expect all outputs at reset values and no pulses. A following full frame with 0xFFFF_FFFF is received correctly.
- Send 3 back-to-back frames, each followed by 8 us of cs_n high, with new tx_data loaded between frames. Expect each frame's response to match. With SPI_SLAVE_FRAME_CNT_EN defined, frame_cnt=3.
- Issue tx_load twice while tx_ready=0. Expect the second load ignored and the first value transmitted.
